// File: rtl/rect_fill_arbiter.sv
// Round-robin arbiter sharing one rectangle-fill pixel engine among NREQ requesters.
// The winner's rectangle is latched, then scanned row by row at one pixel per clock.
module rect_fill_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*11-1:0] req_x0,
  input  logic [NREQ*11-1:0] req_x1,
  input  logic [NREQ*11-1:0] req_y0,
  input  logic [NREQ*11-1:0] req_y1,
  input  logic [NREQ*CW-1:0] req_color,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               pixel_valid,
  output logic [10:0]        xDraw,
  output logic [10:0]        yDraw,
  output logic [CW-1:0]      color_out
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr, win, pick;
  logic          found;
  logic [10:0]   xmin, xmax, ymax;
  logic [10:0]   sx0, sx1, sy0, sy1;
  logic [CW-1:0] scol;

  // Descending scan so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    jj    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (req[jj]) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  always_comb begin
    sx0  = '0;
    sx1  = '0;
    sy0  = '0;
    sy1  = '0;
    scol = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        sx0  = req_x0[i*11 +: 11];
        sx1  = req_x1[i*11 +: 11];
        sy0  = req_y0[i*11 +: 11];
        sy1  = req_y1[i*11 +: 11];
        scol = req_color[i*CW +: CW];
      end
    end
  end

  assign busy        = (state != IDLE);
  assign pixel_valid = (state == DRAW);

  // xDraw/yDraw double as the scan counters so they hold while no pixel is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win       <= '0;
      grant     <= '0;
      done      <= '0;
      xmin      <= '0;
      xmax      <= '0;
      ymax      <= '0;
      xDraw     <= '0;
      yDraw     <= '0;
      color_out <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            win         <= pick;
            grant       <= '0;
            grant[pick] <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          xmin      <= (sx0 < sx1) ? sx0 : sx1;
          xmax      <= (sx0 < sx1) ? sx1 : sx0;
          ymax      <= (sy0 < sy1) ? sy1 : sy0;
          xDraw     <= (sx0 < sx1) ? sx0 : sx1;
          yDraw     <= (sy0 < sy1) ? sy0 : sy1;
          color_out <= scol;
          state     <= DRAW;
        end
        DRAW: begin
          if (xDraw == xmax && yDraw == ymax) begin
            done  <= grant;
            state <= DONE;
          end else if (xDraw == xmax) begin
            xDraw <= xmin;
            yDraw <= yDraw + 11'd1;
          end else begin
            xDraw <= xDraw + 11'd1;
          end
        end
        default: begin
          grant  <= '0;
          rr_ptr <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rect_fill_arbiter.sv
// Randomized self-checking bench for rect_fill_arbiter against a rule-level model
// (queue of expected pixels, first-set-bit-from-pointer arbitration).
module tb_rect_fill_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [43:0] req_x0, req_x1, req_y0, req_y1;
  logic [11:0] req_color;
  logic [3:0]  grant, done;
  logic        busy, pixel_valid;
  logic [10:0] xDraw, yDraw;
  logic [2:0]  color_out;

  int errors = 0;
  int checks = 0;

  rect_fill_arbiter #(.NREQ(4), .CW(3)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
    .req_color(req_color), .grant(grant), .done(done), .busy(busy),
    .pixel_valid(pixel_valid), .xDraw(xDraw), .yDraw(yDraw), .color_out(color_out)
  );

  always #5 clk = ~clk;

  int rx0[4], rx1[4], ry0[4], ry1[4], rc[4];
  int ptr_m;
  int ex[$], ey[$];
  int ecol;

  int gx[$], gy[$], gc[$];
  int cap_to, cap_win, cap_glat, cap_plat, cap_multi, cap_gchg, cap_done;
  int cap_post_grant, cap_post_done, cap_post_busy, cap_post_x, cap_post_y;
  int mut_at, drop_mode;

  task automatic pack();
    for (int i = 0; i < 4; i++) begin
      req_x0[i*11 +: 11]  = 11'(rx0[i]);
      req_x1[i*11 +: 11]  = 11'(rx1[i]);
      req_y0[i*11 +: 11]  = 11'(ry0[i]);
      req_y1[i*11 +: 11]  = 11'(ry1[i]);
      req_color[i*3 +: 3] = 3'(rc[i]);
    end
  endtask

  task automatic set_rect(int i, int x0, int x1, int y0, int y1, int c);
    rx0[i] = x0; rx1[i] = x1; ry0[i] = y0; ry1[i] = y1; rc[i] = c;
    pack();
  endtask

  function automatic int model_pick(logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
    return -1;
  endfunction

  // Expected scan: every (x,y) of the normalised box, rows outer, columns inner.
  task automatic build_exp(int w);
    int xl, xh, yl, yh;
    xl = (rx0[w] < rx1[w]) ? rx0[w] : rx1[w];
    xh = (rx0[w] < rx1[w]) ? rx1[w] : rx0[w];
    yl = (ry0[w] < ry1[w]) ? ry0[w] : ry1[w];
    yh = (ry0[w] < ry1[w]) ? ry1[w] : ry0[w];
    ex.delete(); ey.delete();
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        ex.push_back(x); ey.push_back(y);
      end
    ecol = rc[w];
  endtask

  // Observes one transaction starting at a negedge; records but does not judge.
  task automatic capture();
    int n;
    logic [3:0] g0;
    gx.delete(); gy.delete(); gc.delete();
    cap_to = 0; cap_win = -1; cap_plat = -1; cap_multi = 0; cap_gchg = 0; cap_done = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (grant == 4'd0 && n < 20);
    cap_glat = n;
    if (grant == 4'd0) begin cap_to = 1; return; end
    if (!$onehot(grant)) cap_multi = 1;
    for (int i = 0; i < 4; i++) if (grant[i]) cap_win = i;
    g0 = grant;
    n = 0;
    while (n < 5000) begin
      @(negedge clk); n++;
      if (grant != g0) cap_gchg = 1;
      if ($countones(grant) > 1) cap_multi = 1;
      if (pixel_valid) begin
        if (cap_plat < 0) cap_plat = n;
        gx.push_back(int'(xDraw)); gy.push_back(int'(yDraw)); gc.push_back(int'(color_out));
        if (gx.size() == mut_at) begin
          rx1[2] = 100; ry1[2] = 50; rc[2] = 1; pack();
          req[2] = 1'b0;
        end
      end
      if (done != 4'd0) begin cap_done = int'(done); break; end
    end
    if (cap_done == 0) cap_to = 1;
    if (drop_mode == 1) req[cap_win] = 1'b0;
    if (drop_mode == 2) req = 4'd0;
    @(negedge clk);
    cap_post_grant = int'(grant); cap_post_done = int'(done); cap_post_busy = int'(busy);
    cap_post_x = int'(xDraw); cap_post_y = int'(yDraw);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'd0; mut_at = -1; drop_mode = 1;
    for (int i = 0; i < 4; i++) set_rect(i, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, done, busy, pixel_valid, xDraw, yDraw, color_out} !== 35'd0)
      $display("FAIL reset_outputs: got %h want 0", {grant, done, busy, pixel_valid, xDraw, yDraw, color_out});
    reset = 1'b0; ptr_m = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== 4'd0)
      $display("FAIL idle_no_req: busy=%0d grant=%0d want 0 0", busy, grant);
    if (busy !== 1'b0 || grant !== 4'd0) errors++;
    if ({grant, done, busy, pixel_valid, xDraw, yDraw, color_out} !== 35'd0) errors++;
  endtask

  task automatic test_round_robin();
    int w;
    for (int i = 0; i < 4; i++) set_rect(i, 10 * i, 10 * i, i, i, i + 1);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      w = model_pick(req);
      drop_mode = (t == 4) ? 2 : 0;
      capture();
      checks++;
      if (cap_to != 0 || cap_win != w) begin
        errors++; $display("FAIL rr_winner t=%0d: got %0d want %0d", t, cap_win, w);
      end
      checks++;
      if (cap_multi != 0 || cap_done != (1 << w) || gx.size() != 1) begin
        errors++;
        $display("FAIL rr_onehot_done t=%0d: multi=%0d done=%0d pix=%0d want 0 %0d 1",
                 t, cap_multi, cap_done, gx.size(), 1 << w);
      end
      ptr_m = (w + 1) % 4;
    end
  endtask

  task automatic test_shapes();
    int tbl[5][6] = '{'{0, 0, 2, 0, 1, 5}, '{1, 10, 8, 4, 4, 3}, '{2, 2047, 2047, 2046, 2047, 7},
                      '{3, 500, 500, 20, 17, 2}, '{0, 9, 9, 9, 9, 1}};
    int w;
    drop_mode = 1;
    for (int t = 0; t < 5; t++) begin
      w = tbl[t][0];
      set_rect(w, tbl[t][1], tbl[t][2], tbl[t][3], tbl[t][4], tbl[t][5]);
      build_exp(w);
      req = 4'd0; req[w] = 1'b1;
      capture();
      checks++;
      if (cap_to != 0 || cap_win != w || cap_glat != 1 || cap_plat != 1) begin
        errors++;
        $display("FAIL shape_grant t=%0d: win=%0d glat=%0d plat=%0d to=%0d want %0d 1 1 0",
                 t, cap_win, cap_glat, cap_plat, cap_to, w);
      end
      checks++;
      if (gx.size() != ex.size()) begin
        errors++; $display("FAIL shape_count t=%0d: got %0d want %0d", t, gx.size(), ex.size());
      end
      for (int p = 0; p < ex.size() && p < gx.size(); p++) begin
        checks++;
        if (gx[p] != ex[p] || gy[p] != ey[p] || gc[p] != ecol) begin
          errors++;
          $display("FAIL shape_pixel t=%0d p=%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   t, p, gx[p], gy[p], gc[p], ex[p], ey[p], ecol);
        end
      end
      checks++;
      if (cap_done != (1 << w) || cap_gchg != 0) begin
        errors++; $display("FAIL shape_done t=%0d: got %0d gchg=%0d want %0d", t, cap_done, cap_gchg, 1 << w);
      end
      checks++;
      if (cap_post_grant != 0 || cap_post_done != 0 || cap_post_busy != 0 ||
          cap_post_x != ex[ex.size()-1] || cap_post_y != ey[ey.size()-1]) begin
        errors++;
        $display("FAIL shape_after t=%0d: g=%0d d=%0d b=%0d xy=(%0d,%0d) want 0 0 0 (%0d,%0d)",
                 t, cap_post_grant, cap_post_done, cap_post_busy, cap_post_x, cap_post_y,
                 ex[ex.size()-1], ey[ey.size()-1]);
      end
      ptr_m = (w + 1) % 4;
    end
  endtask

  task automatic test_stability();
    set_rect(2, 3, 6, 1, 2, 6);
    build_exp(2);
    req = 4'b0100; mut_at = 2; drop_mode = 1;
    capture();
    mut_at = -1;
    checks++;
    if (cap_to != 0 || cap_win != 2 || cap_done != 4) begin
      errors++; $display("FAIL stab_done: win=%0d done=%0d want 2 4", cap_win, cap_done);
    end
    checks++;
    if (gx.size() != ex.size()) begin
      errors++; $display("FAIL stab_count: got %0d want %0d", gx.size(), ex.size());
    end
    for (int p = 0; p < ex.size() && p < gx.size(); p++) begin
      checks++;
      if (gx[p] != ex[p] || gy[p] != ey[p] || gc[p] != ecol) begin
        errors++;
        $display("FAIL stab_pixel p=%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 p, gx[p], gy[p], gc[p], ex[p], ey[p], ecol);
      end
    end
    ptr_m = 3;
  endtask

  task automatic test_random();
    int w, xa, ya, xb, yb;
    drop_mode = 1;
    req = 4'd0;
    for (int t = 0; t < 40; t++) begin
      if (req == 4'd0) begin
        req = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) begin
          xa = $urandom_range(0, 2047); ya = $urandom_range(0, 2047);
          xb = xa + $urandom_range(0, 3); yb = ya + $urandom_range(0, 2);
          if (xb > 2047) xb = 2047;
          if (yb > 2047) yb = 2047;
          if ($urandom_range(0, 1) == 1) set_rect(i, xb, xa, yb, ya, $urandom_range(0, 7));
          else set_rect(i, xa, xb, ya, yb, $urandom_range(0, 7));
        end
      end
      w = model_pick(req);
      build_exp(w);
      capture();
      checks++;
      if (cap_to != 0 || cap_win != w || cap_multi != 0 || cap_done != (1 << w)) begin
        errors++;
        $display("FAIL rand_arb t=%0d: win=%0d done=%0d multi=%0d want %0d %0d 0",
                 t, cap_win, cap_done, cap_multi, w, 1 << w);
      end
      checks++;
      if (gx.size() != ex.size()) begin
        errors++; $display("FAIL rand_count t=%0d: got %0d want %0d", t, gx.size(), ex.size());
      end else begin
        for (int p = 0; p < ex.size(); p++)
          if (gx[p] != ex[p] || gy[p] != ey[p] || gc[p] != ecol) begin
            errors++;
            $display("FAIL rand_pixel t=%0d p=%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     t, p, gx[p], gy[p], gc[p], ex[p], ey[p], ecol);
            break;
          end
      end
      ptr_m = (w + 1) % 4;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_rect(3, 0, 9, 0, 9, 4);
    req = 4'b1000;
    n = 0;
    do begin @(negedge clk); n++; end while (pixel_valid !== 1'b1 && n < 20);
    repeat (4) @(negedge clk);
    checks++;
    if (pixel_valid !== 1'b1) begin
      errors++; $display("FAIL mid_drawing: pixel_valid=%0d want 1", pixel_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({grant, done, busy, pixel_valid, xDraw, yDraw, color_out} !== 35'd0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", {grant, done, busy, pixel_valid, xDraw, yDraw, color_out});
    end
    n = 0;
    repeat (3) begin @(negedge clk); if (done !== 4'd0) n++; end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL reset_no_done: got %0d pulses want 0", n);
    end
    reset = 1'b0; ptr_m = 0;
    build_exp(3);
    drop_mode = 1;
    capture();
    checks++;
    if (cap_to != 0 || cap_win != model_pick(4'b1000) || cap_done != 8 || gx.size() != ex.size()) begin
      errors++;
      $display("FAIL after_reset: win=%0d done=%0d pix=%0d want 3 8 %0d", cap_win, cap_done, gx.size(), ex.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_shapes();
    test_stability();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
